// File: rtl/stream_demux_1to2.sv
// stream_demux_1to2: routes one stream into two independent FIFO legs; DEMUX_CNT_EN adds per-leg handshake counters.
module stream_demux_1to2 #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_sel_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic              a_valid_o,
    output logic              b_valid_o,
    input  logic              a_ready_i,
    input  logic              b_ready_i,
    output logic [DATA_W-1:0] a_data_o,
`ifdef DEMUX_CNT_EN
    output logic [15:0]       a_cnt_o,
    output logic [15:0]       b_cnt_o,
    output logic [DATA_W-1:0] b_data_o
`else
    output logic [DATA_W-1:0] b_data_o
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [1:0]             full, vld, push, rdy;
    logic [1:0][DATA_W-1:0] dat;

    assign rdy        = {b_ready_i, a_ready_i};
    assign in_ready_o = !rst_i && !(in_sel_i ? full[1] : full[0]);
    assign a_valid_o  = vld[0];
    assign b_valid_o  = vld[1];
    assign a_data_o   = dat[0];
    assign b_data_o   = dat[1];

    for (genvar g = 0; g < 2; g++) begin : g_leg
        logic [DATA_W-1:0] mem_q [DEPTH];
        logic [PW-1:0]     wr_q, rd_q;
        logic [CW-1:0]     cnt_q;
        logic              pop;
        assign push[g] = in_valid_i && in_ready_o && (in_sel_i == 1'(g));
        assign pop     = vld[g] && rdy[g];
        assign full[g] = cnt_q == CW'(DEPTH);
        assign vld[g]  = cnt_q != '0;
        // Empty legs present zeros even though stale words remain in storage.
        assign dat[g]  = vld[g] ? mem_q[rd_q] : '0;
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
                for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            end else begin
                if (push[g]) begin
                    mem_q[wr_q] <= in_data_i;
                    wr_q        <= (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
                end
                if (pop) rd_q <= (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
                cnt_q <= cnt_q + CW'(push[g]) - CW'(pop);
            end
        end
    end

`ifdef DEMUX_CNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_cnt_o <= '0;
            b_cnt_o <= '0;
        end else begin
            a_cnt_o <= a_cnt_o + 16'(push[0]);
            b_cnt_o <= b_cnt_o + 16'(push[1]);
        end
    end
`endif
endmodule

// File: tb/tb_stream_demux_1to2.sv
// tb_stream_demux_1to2: queue-model bench with directed scenarios and random traffic; DEMUX_CNT_EN adds counter checks.
module tb_stream_demux_1to2;
    localparam int DW    = 8;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1, in_valid_i = 1'b0, in_sel_i = 1'b0, a_ready_i = 1'b0, b_ready_i = 1'b0;
    logic [DW-1:0] in_data_i = '0;
    logic          in_ready_o, a_valid_o, b_valid_o;
    logic [DW-1:0] a_data_o, b_data_o;
    logic [15:0]   a_cnt_o, b_cnt_o;

    int            checks = 0, errors = 0;
    logic [DW-1:0] qa[$], qb[$];
    logic [15:0]   ca = '0, cb = '0;

    always #5 clk = ~clk;

    stream_demux_1to2 #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst_i), .in_data_i(in_data_i), .in_sel_i(in_sel_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .a_valid_o(a_valid_o), .b_valid_o(b_valid_o),
        .a_ready_i(a_ready_i), .b_ready_i(b_ready_i),
        .a_data_o(a_data_o),
`ifdef DEMUX_CNT_EN
        .a_cnt_o(a_cnt_o), .b_cnt_o(b_cnt_o),
`endif
        .b_data_o(b_data_o)
    );

`ifndef DEMUX_CNT_EN
    assign a_cnt_o = '0;
    assign b_cnt_o = '0;
`endif

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, compare outputs with the queue model, then advance the model across the edge.
    task automatic cycle(input logic r, input logic v, input logic s, input logic [DW-1:0] d,
                         input logic ar, input logic br);
        logic rdy;
        @(negedge clk);
        rst_i = r; in_valid_i = v; in_sel_i = s; in_data_i = d; a_ready_i = ar; b_ready_i = br;
        #1;
        rdy = !r && (s ? qb.size() < DEPTH : qa.size() < DEPTH);
        chk("in_ready", in_ready_o, rdy);
        chk("a_valid", a_valid_o, qa.size() != 0);
        chk("b_valid", b_valid_o, qb.size() != 0);
        chk("a_data", a_data_o, qa.size() != 0 ? qa[0] : '0);
        chk("b_data", b_data_o, qb.size() != 0 ? qb[0] : '0);
`ifdef DEMUX_CNT_EN
        chk("a_cnt", a_cnt_o, ca);
        chk("b_cnt", b_cnt_o, cb);
`endif
        if (r) begin
            qa.delete(); qb.delete(); ca = '0; cb = '0;
        end else begin
            if (qa.size() != 0 && ar) void'(qa.pop_front());
            if (qb.size() != 0 && br) void'(qb.pop_front());
            if (v && rdy) begin
                if (s) begin qb.push_back(d); cb++; end
                else   begin qa.push_back(d); ca++; end
            end
        end
    endtask

    initial begin
        @(posedge clk);
        cycle(1, 0, 0, 8'h00, 0, 0);
        cycle(1, 0, 0, 8'h00, 0, 0);
        chk("rst_in_ready", in_ready_o, 0);
        chk("rst_a_valid", a_valid_o, 0);
        chk("rst_b_valid", b_valid_o, 0);
        chk("rst_a_data", a_data_o, 0);
        chk("rst_b_data", b_data_o, 0);
        cycle(0, 0, 0, 8'h00, 0, 0);
        chk("post_rst_ready", in_ready_o, 1);

        cycle(0, 1, 0, 8'hA5, 1, 1);
        cycle(0, 1, 1, 8'h3C, 1, 1);
        chk("route_a_valid", a_valid_o, 1);
        chk("route_a_data", a_data_o, 8'hA5);
        cycle(0, 0, 0, 8'h00, 1, 1);
        chk("route_b_valid", b_valid_o, 1);
        chk("route_b_data", b_data_o, 8'h3C);
        chk("route_a_drained", a_valid_o, 0);
        cycle(0, 0, 0, 8'h00, 1, 1);

        cycle(0, 1, 0, 8'h01, 0, 1);
        cycle(0, 1, 0, 8'h02, 0, 1);
        cycle(0, 0, 0, 8'h00, 0, 1);
        chk("bp_full_ready_a", in_ready_o, 0);
        cycle(0, 1, 1, 8'h03, 0, 0);
        chk("bp_ready_b", in_ready_o, 1);
        cycle(0, 0, 0, 8'h00, 1, 0);
        chk("bp_first_out", a_data_o, 8'h01);
        chk("bp_b_data", b_data_o, 8'h03);
        cycle(0, 0, 0, 8'h00, 1, 1);
        chk("bp_second_out", a_data_o, 8'h02);
        cycle(0, 0, 0, 8'h00, 1, 1);
        chk("bp_a_empty", a_valid_o, 0);

        cycle(0, 1, 0, 8'h10, 0, 0);
        cycle(0, 1, 0, 8'h11, 1, 0);
        chk("pp_head_before", a_data_o, 8'h10);
        cycle(0, 0, 0, 8'h00, 0, 0);
        chk("pp_head_after", a_data_o, 8'h11);
        chk("pp_valid_after", a_valid_o, 1);
        cycle(0, 0, 0, 8'h00, 1, 0);
        cycle(0, 0, 0, 8'h00, 0, 0);
        chk("pp_count_one", a_valid_o, 0);
        chk("pp_empty_zero", a_data_o, 0);

        cycle(0, 1, 0, 8'h21, 0, 0);
        cycle(0, 1, 0, 8'h22, 0, 0);
        cycle(0, 1, 1, 8'h23, 0, 0);
        cycle(0, 1, 1, 8'h24, 0, 0);
        cycle(1, 1, 0, 8'h25, 1, 1);
        chk("mid_rst_full", a_valid_o, 1);
        chk("mid_rst_ready", in_ready_o, 0);
        cycle(0, 0, 0, 8'h00, 0, 0);
        chk("mid_rst_a_valid", a_valid_o, 0);
        chk("mid_rst_b_valid", b_valid_o, 0);
        chk("mid_rst_b_data", b_data_o, 0);
`ifdef DEMUX_CNT_EN
        chk("mid_rst_a_cnt", a_cnt_o, 0);
        chk("mid_rst_b_cnt", b_cnt_o, 0);
`endif

        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(63) == 0, $urandom_range(9) < 7, 1'($urandom), 8'($urandom),
                  $urandom_range(9) < 6, $urandom_range(9) < 6);

`ifdef DEMUX_CNT_EN
        cycle(1, 0, 0, 8'h00, 0, 0);
        for (int i = 0; i < 65537; i++) cycle(0, 1, 1, 8'(i), 0, 1);
        cycle(0, 0, 0, 8'h00, 1, 1);
        chk("wrap_b_cnt", b_cnt_o, 16'd1);
        chk("wrap_a_cnt", a_cnt_o, 16'd0);
`endif
        cycle(0, 0, 0, 8'h00, 1, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/stream_demux_1to2.md
STREAM_DEMUX_1TO2 -- requirements
Module: stream_demux_1to2

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, width of the data path.
REQ-002 SHALL provide parameter DEPTH, default 2, entries per output-leg buffer (legal 2..16).
REQ-003 SHALL provide port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst_i, input, 1, reset, synchronous and active-high.
REQ-005 SHALL provide port in_data_i, input, DATA_W, input stream data.
REQ-006 SHALL provide port in_sel_i, input, 1, leg select (0 = leg A, 1 = leg B), qualified by in_valid_i.
REQ-007 SHALL provide port in_valid_i, input, 1, input word present.
REQ-008 SHALL provide port in_ready_o, output, 1, block can accept the presented word.
REQ-009 SHALL provide ports a_data_o and b_data_o, output, DATA_W each, head word of leg A and leg B.
REQ-010 SHALL provide ports a_valid_o and b_valid_o, output, 1 each, leg head word valid.
REQ-011 SHALL provide ports a_ready_i and b_ready_i, input, 1 each, downstream accepts the leg head word.
REQ-012 SHALL provide ports a_cnt_o and b_cnt_o, output, 16 each, only when DEMUX_CNT_EN is defined.

Function
REQ-013 Input handshake SHALL complete on a rising edge where in_valid_i and in_ready_o are both 1; the word SHALL be written to the leg named by in_sel_i.
REQ-014 in_ready_o SHALL be 1 exactly when rst_i is 0 and the leg selected by in_sel_i holds fewer than DEPTH words; it SHALL NOT depend on a_ready_i or b_ready_i.
REQ-015 Each leg SHALL be an independent FIFO with states EMPTY (0 words), PARTIAL (1..DEPTH-1), FULL (DEPTH).
REQ-016 Leg transitions: push only -> count+1; pop only -> count-1; push and pop on the same edge -> count unchanged; pop SHALL be ignored when EMPTY; push SHALL not occur when FULL (per REQ-014).
REQ-017 A leg output handshake SHALL complete on an edge where x_valid_o and x_ready_i are both 1, and the head word is removed.
REQ-018 x_valid_o SHALL be 1 exactly when leg x is not EMPTY; x_data_o SHALL equal the oldest stored word of leg x.
REQ-019 Latency from input handshake edge to x_valid_o high SHALL be 1 cycle when the leg was EMPTY; no combinational path from in_data_i to x_data_o.
REQ-020 Word order SHALL be preserved per leg; no word SHALL be duplicated, dropped, or routed to the unselected leg.
REQ-021 A full leg SHALL NOT block the other leg: a word selecting a non-full leg SHALL be accepted regardless of the other leg's state.
REQ-022 Read/write pointers SHALL wrap from DEPTH-1 to 0 without loss.
REQ-023 x_data_o SHALL be all zeros while leg x is EMPTY.

Reset
REQ-024 While rst_i is 1 on a rising edge, both legs SHALL become EMPTY, pointers 0, storage 0.
REQ-025 During and after reset: in_ready_o 0 while rst_i is 1; a_valid_o, b_valid_o 0; a_data_o, b_data_o 0; counters 0.
REQ-026 Reset asserted mid-operation SHALL discard all buffered words; no handshake SHALL complete on that edge.

Configuration
REQ-027 Macro DEMUX_CNT_EN: when defined, a_cnt_o/b_cnt_o SHALL count completed input handshakes into leg A/B, increment by 1 per handshake, wrap 16'hFFFF -> 0, reset to 0.
REQ-028 When DEMUX_CNT_EN is undefined, counter ports and logic SHALL be absent; all other behaviour identical.

Verification
REQ-029 Reset then idle: rst_i=1 two cycles -> in_ready_o=0, both valids 0, data 0; after release in_ready_o=1.
REQ-030 Routing: push 8'hA5 sel 0, 8'h3C sel 1, both readies 1 -> next cycle a_data_o=8'hA5 a_valid_o=1, then b_data_o=8'h3C b_valid_o=1.
REQ-031 Backpressure: a_ready_i=0, push 8'h01, 8'h02 sel 0 -> leg A FULL, in_ready_o=0 with sel 0, 1 with sel 1; push 8'h03 sel 1 accepted; raise a_ready_i -> 8'h01 then 8'h02 out.
REQ-032 Simultaneous push/pop: leg A holds 8'h10, push 8'h11 sel 0 with a_ready_i=1 -> count stays 1, a_data_o=8'h11 next cycle.
REQ-033 Reset mid-operation: both legs FULL, rst_i=1 one cycle -> valids 0, all buffered words lost, counters 0.
REQ-034 DEMUX_CNT_EN defined: 65537 pushes to leg B -> b_cnt_o=1, a_cnt_o=0.
